// File: rtl/pixel_sampler_pkg.sv
// Shared constants for the pixel sampler: default NCO width, CGA pixel/fpga clock rates and
// the phase-increment calculation used to pick the NCO step at elaboration time.
package pixel_sampler_pkg;

    localparam int     PHASE_W_DEF = 16;
    localparam longint CGA_PX_HZ   = 64'd14318180;
    localparam longint CGA_CLK_HZ  = 64'd126008000;

    // round(f_px / f_clk * 2^width), done in integer Hz so it folds to a constant
    function automatic int phase_inc_calc(input longint f_px, input longint f_clk, input int width);
        longint num;
        num = (f_px <<< width) + (f_clk / 2);
        return int'(num / f_clk);
    endfunction

    localparam int CGA_PHASE_INC = phase_inc_calc(CGA_PX_HZ, CGA_CLK_HZ, PHASE_W_DEF);

endpackage

// File: rtl/bit_synchronizer.sv
// Plain multi-flop synchroniser for a bus of independent asynchronous bits.
// Each bit is synchronised on its own; no cross-bit coherence is implied.
module bit_synchronizer #(
    parameter int SYNC_STAGES = 2,
    parameter int WIDTH       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [SYNC_STAGES];
    logic [WIDTH-1:0] stage_d [SYNC_STAGES];

    always_comb begin
        stage_d[0] = d;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/phase_tracking_sampler.sv
// Oversampling pixel sampler: synchronises video bits, tracks pixel phase with an NCO that is
// re-aligned on every input transition, and emits one mid-pixel sample per pixel plus lock status.
module phase_tracking_sampler
    import pixel_sampler_pkg::*;
#(
    parameter int NB_CHANNELS = 4,
    parameter int SYNC_STAGES = 2,
    parameter int PHASE_W     = PHASE_W_DEF,
    parameter int PHASE_INC   = CGA_PHASE_INC,
    parameter int TOL         = 8192,
    parameter int LOCK_COUNT  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   majority_en,
    input  logic [NB_CHANNELS-1:0] data_in,
    output logic [NB_CHANNELS-1:0] data_out,
    output logic                   data_valid,
    output logic                   edge_seen,
    output logic                   locked,
    output logic [PHASE_W-1:0]     phase_err
);

    localparam int                 CNT_W   = $clog2(LOCK_COUNT + 1);
    localparam logic [PHASE_W-1:0] INC     = PHASE_W'(PHASE_INC);
    localparam logic [PHASE_W:0]   TOL_V   = (PHASE_W + 1)'(TOL);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(LOCK_COUNT);
    localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);

    logic [NB_CHANNELS-1:0] sync_data;

    logic [NB_CHANNELS-1:0] h0_q, h0_d;
    logic [NB_CHANNELS-1:0] h1_q, h1_d;
    logic [NB_CHANNELS-1:0] h2_q, h2_d;
    logic [PHASE_W-1:0]     acc_q, acc_d;
    logic [PHASE_W-1:0]     phase_err_q, phase_err_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   locked_q, locked_d;
    logic [NB_CHANNELS-1:0] data_out_q, data_out_d;
    logic                   data_valid_q, data_valid_d;
    logic                   edge_seen_q, edge_seen_d;

    logic                   edge_det;
    logic [PHASE_W-1:0]     acc_inc;
    logic                   crossing;
    logic [PHASE_W:0]       err_ext;
    logic [PHASE_W:0]       err_mag;
    logic                   in_tol;
    logic [NB_CHANNELS-1:0] maj;
    logic [NB_CHANNELS-1:0] sample;

    bit_synchronizer #(
        .SYNC_STAGES (SYNC_STAGES),
        .WIDTH       (NB_CHANNELS)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (data_in),
        .q     (sync_data)
    );

    assign edge_det = enable && (h0_q != h1_q);
    assign acc_inc  = acc_q + INC;
    // Mid-pixel is where the accumulator MSB rises; the wrap back to 0 is the pixel boundary.
    assign crossing = !acc_q[PHASE_W-1] && acc_inc[PHASE_W-1];

    // One extra bit so the most negative phase still has a representable magnitude.
    assign err_ext = {acc_q[PHASE_W-1], acc_q};
    assign err_mag = err_ext[PHASE_W] ? (~err_ext + 1'b1) : err_ext;
    assign in_tol  = (err_mag <= TOL_V);

    assign maj    = (h0_q & h1_q) | (h0_q & h2_q) | (h1_q & h2_q);
    assign sample = majority_en ? maj : h1_q;

    // data_valid is a single-cycle strobe with no back-pressure: data_out is meaningful in the
    // strobe cycle and simply holds afterwards until the next strobe.
    always_comb begin
        h0_d         = h0_q;
        h1_d         = h1_q;
        h2_d         = h2_q;
        acc_d        = acc_q;
        phase_err_d  = phase_err_q;
        cnt_d        = cnt_q;
        locked_d     = locked_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        edge_seen_d  = 1'b0;

        if (enable) begin
            h0_d = sync_data;
            h1_d = h0_q;
            h2_d = h1_q;
        end

        if (edge_det) begin
            // The edge cycle counts as one clock past the boundary, hence reload with INC, not 0.
            edge_seen_d = 1'b1;
            acc_d       = INC;
            phase_err_d = acc_q;
            if (in_tol) begin
                cnt_d = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
                if (cnt_d == CNT_MAX) begin
                    locked_d = 1'b1;
                end
            end else begin
                cnt_d    = '0;
                locked_d = 1'b0;
            end
        end else if (enable) begin
            acc_d = acc_inc;
            if (crossing) begin
                data_valid_d = 1'b1;
                data_out_d   = sample;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h0_q         <= '0;
            h1_q         <= '0;
            h2_q         <= '0;
            acc_q        <= '0;
            phase_err_q  <= '0;
            cnt_q        <= '0;
            locked_q     <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            edge_seen_q  <= 1'b0;
        end else begin
            h0_q         <= h0_d;
            h1_q         <= h1_d;
            h2_q         <= h2_d;
            acc_q        <= acc_d;
            phase_err_q  <= phase_err_d;
            cnt_q        <= cnt_d;
            locked_q     <= locked_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            edge_seen_q  <= edge_seen_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign edge_seen  = edge_seen_q;
    assign locked     = locked_q;
    assign phase_err  = phase_err_q;

endmodule
